// File: rtl/tag_ram_nway_sync_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tag_ram_nway_sync_if : lookup / write / result bundle of the N-way tag RAM |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface tag_ram_nway_sync_if #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 14,
  parameter int WAYS   = 2
);
  localparam int WWIDTH = $clog2(WAYS);

  logic                   init_done;
  logic                   lk_valid;
  logic [AWIDTH-1:0]      lk_addr;
  logic [TWIDTH-1:0]      lk_tag;
  logic                   lk_rvalid;
  logic                   hit;
  logic [WAYS-1:0]        hit_vec;
  logic [WWIDTH-1:0]      hit_way;
  logic [WAYS*TWIDTH-1:0] rd_tags;
  logic [WWIDTH-1:0]      victim_way;
  logic                   wr_en;
  logic [AWIDTH-1:0]      wr_addr;
  logic [WWIDTH-1:0]      wr_way;
  logic [TWIDTH-1:0]      wr_tag;
  logic                   wr_valid;

  modport master (
    input  init_done, lk_rvalid, hit, hit_vec, hit_way, rd_tags, victim_way,
    output lk_valid, lk_addr, lk_tag, wr_en, wr_addr, wr_way, wr_tag, wr_valid
  );

  modport slave (
    output init_done, lk_rvalid, hit, hit_vec, hit_way, rd_tags, victim_way,
    input  lk_valid, lk_addr, lk_tag, wr_en, wr_addr, wr_way, wr_tag, wr_valid
  );
endinterface
`default_nettype wire

// File: rtl/tag_ram_nway_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tag_ram_nway_sync : N-way set-associative tag store, sync read, hit check, |
// | victim select. Optional macro TAG_RAM_VICTIM_RR_EN: round-robin victim.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tag_ram_nway_sync #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 14,
  parameter int WAYS   = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  tag_ram_nway_sync_if.slave   bus
);
  localparam int DEPTH  = 1 << AWIDTH;
  localparam int WWIDTH = $clog2(WAYS);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [AWIDTH-1:0]   r_ctr;
  logic [TWIDTH-1:0]   r_tag_mem   [DEPTH][WAYS];
  logic [WAYS-1:0]     r_valid_mem [DEPTH];

  logic                   w_run;
  logic                   w_same_set;
  logic [WAYS-1:0]        w_wr_sel;
  logic [WAYS*TWIDTH-1:0] w_fwd_tags;
  logic [WAYS-1:0]        w_fwd_valid;
  logic [WAYS-1:0]        w_hit_vec;
  logic [WWIDTH-1:0]      w_hit_way;
  logic [WWIDTH-1:0]      w_victim;
  logic [WWIDTH-1:0]      w_victim_dflt;

  assign w_run      = (r_state == ST_RUN);
  assign w_same_set = (bus.wr_addr == bus.lk_addr);

  // Way decode; an out-of-range wr_way selects nothing, which drops the write.
  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_wr_sel
      assign w_wr_sel[w] = bus.wr_en && w_run && (bus.wr_way == WWIDTH'(w));
    end
  endgenerate

`ifdef TAG_RAM_VICTIM_RR_EN
  logic [WWIDTH-1:0] r_ptr_mem [DEPTH];
  logic [WWIDTH-1:0] w_ptr_wr;
  logic [WWIDTH-1:0] w_ptr_wr_next;
  logic              w_ptr_adv;

  assign w_ptr_wr      = r_ptr_mem[bus.wr_addr];
  assign w_ptr_wr_next = (w_ptr_wr == WWIDTH'(WAYS - 1)) ? '0 : w_ptr_wr + WWIDTH'(1);
  assign w_ptr_adv     = bus.wr_en && w_run && bus.wr_valid && (bus.wr_way == w_ptr_wr);
  assign w_victim_dflt = (w_same_set && w_ptr_adv) ? w_ptr_wr_next : r_ptr_mem[bus.lk_addr];

  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (r_state == ST_INIT) begin
        r_ptr_mem[r_ctr] <= '0;
      end else if (w_ptr_adv) begin
        r_ptr_mem[bus.wr_addr] <= w_ptr_wr_next;
      end
    end
  end
`else
  assign w_victim_dflt = '0;
`endif

  // Write-first: a same-set write at this edge is forwarded into the lookup result.
  always_comb begin
    w_fwd_tags  = '0;
    w_fwd_valid = '0;
    w_hit_vec   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_same_set && w_wr_sel[w]) begin
        w_fwd_tags[w*TWIDTH +: TWIDTH] = bus.wr_tag;
        w_fwd_valid[w]                 = bus.wr_valid;
      end else begin
        w_fwd_tags[w*TWIDTH +: TWIDTH] = r_tag_mem[bus.lk_addr][w];
        w_fwd_valid[w]                 = r_valid_mem[bus.lk_addr][w];
      end
      w_hit_vec[w] = w_fwd_valid[w] && (w_fwd_tags[w*TWIDTH +: TWIDTH] == bus.lk_tag);
    end
  end

  always_comb begin
    w_hit_way = '0;
    w_victim  = w_victim_dflt;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) begin
        w_hit_way = WWIDTH'(w);
      end
      if (!w_fwd_valid[w]) begin
        w_victim = WWIDTH'(w);
      end
    end
  end

  // Tag contents survive reset; only valid bits are cleared, by the sweep.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (r_state == ST_INIT) begin
        r_valid_mem[r_ctr] <= '0;
      end else begin
        for (int w = 0; w < WAYS; w++) begin
          if (w_wr_sel[w]) begin
            r_tag_mem[bus.wr_addr][w]   <= bus.wr_tag;
            r_valid_mem[bus.wr_addr][w] <= bus.wr_valid;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state        <= ST_INIT;
      r_ctr          <= '0;
      bus.init_done  <= 1'b0;
      bus.lk_rvalid  <= 1'b0;
      bus.hit        <= 1'b0;
      bus.hit_vec    <= '0;
      bus.hit_way    <= '0;
      bus.victim_way <= '0;
      bus.rd_tags    <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          bus.lk_rvalid <= 1'b0;
          r_ctr         <= r_ctr + AWIDTH'(1);
          if (r_ctr == AWIDTH'(DEPTH - 1)) begin
            r_state       <= ST_RUN;
            bus.init_done <= 1'b1;
          end
        end
        default: begin
          bus.lk_rvalid <= bus.lk_valid;
          if (bus.lk_valid) begin
            bus.hit        <= |w_hit_vec;
            bus.hit_vec    <= w_hit_vec;
            bus.hit_way    <= w_hit_way;
            bus.victim_way <= w_victim;
            bus.rd_tags    <= w_fwd_tags;
          end
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_tag_ram_nway_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tag_ram_nway_sync : self-checking bench with array-based reference model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_tag_ram_nway_sync;
  localparam int AW = 3;
  localparam int TW = 14;
  localparam int WY = 2;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tag_ram_nway_sync_if #(.AWIDTH(AW), .TWIDTH(TW), .WAYS(WY)) bus ();

  tag_ram_nway_sync #(.AWIDTH(AW), .TWIDTH(TW), .WAYS(WY)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays of what each (set, way) holds.
  logic [TW-1:0] m_tag   [DEPTH][WY];
  bit            m_valid [DEPTH][WY];
  bit            m_known [DEPTH][WY];
  int            m_ptr   [DEPTH];
  bit            m_run;

  bit            exp_rv;
  logic [WY-1:0] exp_hv;
  bit            exp_hit;
  int            exp_hw;
  int            exp_vic;
  logic [WY*TW-1:0] exp_tags;
  logic [WY*TW-1:0] exp_mask;

  task automatic model_reset();
    for (int s = 0; s < DEPTH; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WY; w++) m_valid[s][w] = 1'b0;
    end
    m_run = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.lk_valid = 1'b0; bus.lk_addr = '0; bus.lk_tag = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_way = '0; bus.wr_tag = '0; bus.wr_valid = 1'b0;
  endtask

  // One clock: drive a lookup and/or a write, then advance the model (write first).
  task automatic step(input bit lv, input int la, input logic [TW-1:0] lt,
                      input bit we, input int wa, input int ww,
                      input logic [TW-1:0] wt, input bit wv);
    bus.lk_valid = lv; bus.lk_addr = AW'(la); bus.lk_tag = lt;
    bus.wr_en = we; bus.wr_addr = AW'(wa); bus.wr_way = ww[0]; bus.wr_tag = wt; bus.wr_valid = wv;
    @(posedge clock); #1;
    exp_rv = 1'b0;
    if (m_run) begin
      if (we && ww < WY) begin
        m_tag[wa][ww] = wt; m_valid[wa][ww] = wv; m_known[wa][ww] = 1'b1;
`ifdef TAG_RAM_VICTIM_RR_EN
        if (wv && ww == m_ptr[wa]) m_ptr[wa] = (m_ptr[wa] + 1) % WY;
`endif
      end
      if (lv) begin
        exp_rv = 1'b1;
        exp_hv = '0; exp_tags = '0; exp_mask = '0;
        for (int w = 0; w < WY; w++) begin
          if (m_valid[la][w] && m_tag[la][w] == lt) exp_hv[w] = 1'b1;
          if (m_known[la][w]) begin
            exp_tags[w*TW +: TW] = m_tag[la][w];
            exp_mask[w*TW +: TW] = '1;
          end
        end
        exp_hit = |exp_hv;
        exp_hw = 0;
`ifdef TAG_RAM_VICTIM_RR_EN
        exp_vic = m_ptr[la];
`else
        exp_vic = 0;
`endif
        for (int w = WY - 1; w >= 0; w--) begin
          if (exp_hv[w]) exp_hw = w;
          if (!m_valid[la][w]) exp_vic = w;
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %0b expected 0", bus.init_done); end
    checks++; if (bus.lk_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b expected 0", bus.lk_rvalid); end
    checks++; if ({bus.hit, bus.hit_vec, bus.hit_way, bus.victim_way} !== 5'b0) begin
      errors++; $display("FAIL reset_hit_outputs: got %0h expected 0", {bus.hit, bus.hit_vec, bus.hit_way, bus.victim_way}); end
    checks++; if (bus.rd_tags !== '0) begin errors++; $display("FAIL reset_rd_tags: got %0h expected 0", bus.rd_tags); end
    model_reset();
    reset_n = 1'b1;
    // Requests during the sweep must be ignored.
    bus.lk_valid = 1'b1; bus.lk_addr = 3'd6; bus.lk_tag = 14'h0055;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_way = 1'b0; bus.wr_tag = 14'h0055; bus.wr_valid = 1'b1;
    n = 0;
    while (n < 50) begin
      @(posedge clock); #1; n++;
      checks++; if (bus.lk_rvalid !== 1'b0) begin errors++; $display("FAIL init_rvalid: got %0b expected 0 at cycle %0d", bus.lk_rvalid, n); end
      if (bus.init_done === 1'b1) break;
    end
    idle_inputs();
    checks++; if (n !== 8) begin errors++; $display("FAIL init_latency: got %0d expected 8 cycles", n); end
    m_run = 1'b1;
    step(1, 6, 14'h0055, 0, 0, 0, 0, 0);
    checks++; if (bus.lk_rvalid !== 1'b1 || bus.hit !== 1'b0) begin
      errors++; $display("FAIL init_write_ignored: got rvalid=%0b hit=%0b expected rvalid=1 hit=0", bus.lk_rvalid, bus.hit); end
  endtask

  task automatic test_hit();
    step(0, 0, 0, 1, 3, 1, 14'h1ABC, 1);
    checks++; if (bus.lk_rvalid !== 1'b0) begin errors++; $display("FAIL write_only_rvalid: got %0b expected 0", bus.lk_rvalid); end
    step(1, 3, 14'h1ABC, 0, 0, 0, 0, 0);
    checks++; if (bus.lk_rvalid !== 1'b1) begin errors++; $display("FAIL hit_rvalid: got %0b expected 1", bus.lk_rvalid); end
    checks++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL hit_flag: got %0b expected 1", bus.hit); end
    checks++; if (bus.hit_vec !== 2'b10) begin errors++; $display("FAIL hit_vec: got %b expected 10", bus.hit_vec); end
    checks++; if (bus.hit_way !== 1'b1) begin errors++; $display("FAIL hit_way: got %0d expected 1", bus.hit_way); end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.lk_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_one_cycle: got %0b expected 0", bus.lk_rvalid); end
  endtask

  task automatic test_miss();
    step(1, 3, 14'h0ABC, 0, 0, 0, 0, 0);
    checks++; if (bus.hit !== 1'b0 || bus.hit_vec !== 2'b00) begin
      errors++; $display("FAIL miss_hit: got hit=%0b vec=%b expected 0/00", bus.hit, bus.hit_vec); end
    checks++; if (bus.rd_tags[27:14] !== 14'h1ABC) begin errors++; $display("FAIL miss_rd_tag1: got %0h expected 1abc", bus.rd_tags[27:14]); end
    checks++; if (bus.victim_way !== 1'b0) begin errors++; $display("FAIL miss_victim: got %0d expected 0", bus.victim_way); end
  endtask

  task automatic test_write_first();
    step(1, 5, 14'h0011, 1, 5, 0, 14'h0011, 1);
    checks++; if (bus.hit !== 1'b1 || bus.hit_way !== 1'b0) begin
      errors++; $display("FAIL write_first_hit: got hit=%0b way=%0d expected 1/0", bus.hit, bus.hit_way); end
    step(0, 0, 0, 1, 5, 0, 14'h0011, 0);
    step(1, 5, 14'h0011, 0, 0, 0, 0, 0);
    checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL invalidate_miss: got %0b expected 0", bus.hit); end
  endtask

  task automatic test_victim();
    int seq [4];
`ifdef TAG_RAM_VICTIM_RR_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 0};
`endif
    step(0, 0, 0, 1, 2, 0, 14'h0200, 1);
    step(0, 0, 0, 1, 2, 1, 14'h0201, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 2, 14'h3FFF, 0, 0, 0, 0, 0);
      checks++; if (bus.victim_way !== seq[i][0]) begin
        errors++; $display("FAIL victim_seq[%0d]: got %0d expected %0d", i, bus.victim_way, seq[i]); end
      step(0, 0, 0, 1, 2, seq[i], 14'h0300 + 14'(i), 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), 14'h0100 + 14'($urandom_range(0, 3)),
           $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, WY - 1),
           14'h0100 + 14'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      checks++; if (bus.lk_rvalid !== exp_rv) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %0b expected %0b", i, bus.lk_rvalid, exp_rv); end
      if (exp_rv) begin
        checks++; if (bus.hit_vec !== exp_hv || bus.hit !== exp_hit) begin
          errors++; $display("FAIL rnd_hit[%0d]: got vec=%b hit=%0b expected vec=%b hit=%0b", i, bus.hit_vec, bus.hit, exp_hv, exp_hit); end
        checks++; if (bus.hit_way !== exp_hw[0]) begin errors++; $display("FAIL rnd_hit_way[%0d]: got %0d expected %0d", i, bus.hit_way, exp_hw); end
        checks++; if (bus.victim_way !== exp_vic[0]) begin errors++; $display("FAIL rnd_victim[%0d]: got %0d expected %0d", i, bus.victim_way, exp_vic); end
        checks++; if (((bus.rd_tags ^ exp_tags) & exp_mask) !== '0) begin
          errors++; $display("FAIL rnd_rd_tags[%0d]: got %0h expected %0h (mask %0h)", i, bus.rd_tags, exp_tags, exp_mask); end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < DEPTH; s++) begin
      step(1, s, 14'h0100 + 14'($urandom_range(0, 3)), 0, 0, 0, 0, 0);
      checks++; if (bus.lk_rvalid !== 1'b1 || bus.hit_vec !== exp_hv) begin
        errors++; $display("FAIL b2b[%0d]: got rvalid=%0b vec=%b expected 1/%b", s, bus.lk_rvalid, bus.hit_vec, exp_hv); end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.lk_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end_rvalid: got %0b expected 0", bus.lk_rvalid); end
  endtask

  task automatic test_reset_mid_init();
    int n;
    step(0, 0, 0, 1, 3, 1, 14'h1ABC, 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    checks++; if (bus.init_done !== 1'b0 || bus.lk_rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got done=%0b rvalid=%0b expected 0/0", bus.init_done, bus.lk_rvalid); end
    model_reset();
    reset_n = 1'b1;
    n = 0;
    while (n < 50) begin
      @(posedge clock); #1; n++;
      if (bus.init_done === 1'b1) break;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL mid_reset_latency: got %0d expected 8 cycles", n); end
    m_run = 1'b1;
    step(1, 3, 14'h1ABC, 0, 0, 0, 0, 0);
    checks++; if (bus.lk_rvalid !== 1'b1 || bus.hit !== 1'b0) begin
      errors++; $display("FAIL mid_reset_set3: got rvalid=%0b hit=%0b expected 1/0", bus.lk_rvalid, bus.hit); end
  endtask

  initial begin
    for (int s = 0; s < DEPTH; s++)
      for (int w = 0; w < WY; w++) begin m_known[s][w] = 1'b0; m_tag[s][w] = '0; end
    exp_rv = 0; exp_hv = '0; exp_hit = 0; exp_hw = 0; exp_vic = 0; exp_tags = '0; exp_mask = '0;
    test_reset();
    test_hit();
    test_miss();
    test_write_first();
    test_victim();
    test_random();
    test_back_to_back();
    test_reset_mid_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
